// File: rtl/vga_frame_monitor.sv
// Passive VGA stream monitor: recovers raster position from hsync/vsync, captures
// active pixels and reports per-frame colour statistics plus timing errors.
module vga_frame_monitor #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_TOTAL  = 800,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_TOTAL  = 525,
  parameter logic       SYNC_POL = 1'b0,
  parameter int         PIX_LAT  = 1,
  parameter logic [7:0] COLOR_A  = 8'b000_111_00,
  parameter logic [7:0] COLOR_B  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_data,
  output logic        frame_done,
  output logic [18:0] cnt_a,
  output logic [18:0] cnt_b,
  output logic [18:0] cnt_nz,
  output logic [7:0]  err_count
);

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] H_EDGE  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_LOAD  = 10'(H_ACTIVE + H_FP + 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] V_EDGE  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_EARLY = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {UNLOCKED, H_SYNCED, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hsync_q, vsync_q;
  logic        h_edge, v_edge;
  logic [9:0]  hcnt, vcnt;
  logic        err, first_v, upd;
  logic [18:0] acc_a, acc_b, acc_nz;

  // Registers reset to the asserted level so a sync held active over reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= SYNC_POL;
      vsync_q <= SYNC_POL;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
    end
  end

  assign h_edge = (hsync == SYNC_POL) && (hsync_q != SYNC_POL);
  assign v_edge = (vsync == SYNC_POL) && (vsync_q != SYNC_POL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (h_edge)              hcnt <= H_LOAD;
      else if (hcnt == H_LAST) hcnt <= '0;
      else                     hcnt <= hcnt + 10'd1;

      if (v_edge)                                vcnt <= V_EDGE;
      else if (!h_edge && hcnt == H_LAST)        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= UNLOCKED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    first_v = 1'b0;
    upd     = 1'b0;
    case (state_q)
      UNLOCKED: if (h_edge) state_d = H_SYNCED;
      H_SYNCED: begin
        if (v_edge) begin
          state_d = LOCKED;
          first_v = 1'b1;
        end
      end
      LOCKED: begin
        err = (h_edge && hcnt != H_EDGE) ||
              (v_edge && vcnt != V_EDGE && vcnt != V_EARLY);
        if (err) state_d = UNLOCKED;
        upd = v_edge && !err;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  assign locked = (state_q == LOCKED);

  logic       cur_act;
  logic       d_act, d_lock;
  logic [9:0] d_x, d_y;

  assign cur_act = (hcnt < H_ACT) && (vcnt < V_ACT);

  // Position and lock status are delayed together so they line up with vga_in.
  generate
    if (PIX_LAT == 0) begin : g_nodly
      assign d_act  = cur_act;
      assign d_lock = locked;
      assign d_x    = hcnt;
      assign d_y    = vcnt;
    end else begin : g_dly
      logic [PIX_LAT-1:0] act_sr, lock_sr;
      logic [9:0]         x_sr [PIX_LAT];
      logic [9:0]         y_sr [PIX_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          act_sr  <= '0;
          lock_sr <= '0;
          for (int i = 0; i < PIX_LAT; i++) begin
            x_sr[i] <= '0;
            y_sr[i] <= '0;
          end
        end else begin
          act_sr[0]  <= cur_act;
          lock_sr[0] <= locked;
          x_sr[0]    <= hcnt;
          y_sr[0]    <= vcnt;
          for (int i = 1; i < PIX_LAT; i++) begin
            act_sr[i]  <= act_sr[i-1];
            lock_sr[i] <= lock_sr[i-1];
            x_sr[i]    <= x_sr[i-1];
            y_sr[i]    <= y_sr[i-1];
          end
        end
      end

      assign d_act  = act_sr[PIX_LAT-1];
      assign d_lock = lock_sr[PIX_LAT-1];
      assign d_x    = x_sr[PIX_LAT-1];
      assign d_y    = y_sr[PIX_LAT-1];
    end
  endgenerate

  logic cap, inc_a, inc_b, inc_nz;

  assign cap    = d_act && d_lock;
  assign inc_a  = cap && (vga_in == COLOR_A);
  assign inc_b  = cap && (vga_in == COLOR_B);
  assign inc_nz = cap && (vga_in != 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
    end else begin
      pix_valid <= cap;
      if (cap) begin
        pix_x    <= d_x;
        pix_y    <= d_y;
        pix_data <= vga_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a      <= '0;
      acc_b      <= '0;
      acc_nz     <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      cnt_nz     <= '0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_done <= upd;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (err || first_v) begin
        acc_a  <= '0;
        acc_b  <= '0;
        acc_nz <= '0;
      end else if (upd) begin
        cnt_a  <= acc_a + 19'(inc_a);
        cnt_b  <= acc_b + 19'(inc_b);
        cnt_nz <= acc_nz + 19'(inc_nz);
        acc_a  <= '0;
        acc_b  <= '0;
        acc_nz <= '0;
      end else begin
        acc_a  <= acc_a + 19'(inc_a);
        acc_b  <= acc_b + 19'(inc_b);
        acc_nz <= acc_nz + 19'(inc_nz);
      end
    end
  end

endmodule
